sobel_frame_ctrl: RTL and testbench

- Frame-level scheduler for the `sobel` window engine.
- Walks every valid KERNEL_MxM window of an IMG_W x IMG_H 8-bit image held in a synchronous-read RAM.
- Runs the `sobel` enable/feed/done handshake once per window, feeding that window's 9 pixels.
- Writes each result to an output RAM. Sits between the image buffer and `sobel`; started by the host or GUI bridge.

---
 rtl/sobel_pkg.sv | 16 +
 rtl/sobel_win_addr_gen.sv | 87 ++++++++
 rtl/sobel_frame_ctrl.sv | 179 +++++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the sobel frame scheduler and its address generator.
package sobel_pkg;

    localparam int KERNEL_MXM_DEF = 3;
    localparam int PIX_W          = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_FEED,
        ST_WAIT,
        ST_WRITE,
        ST_GAP
    } sob_state_e;

endpackage

// File: rtl/sobel_win_addr_gen.sv
// Window/pixel counters for the frame scheduler: raster-order window (r,c),
// in-window pixel position (i,j) and read index k, with derived RAM addresses.
module sobel_win_addr_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int KERNEL_MxM = KERNEL_MXM_DEF,
    parameter int RD_AW      = 6,
    parameter int WR_AW      = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             pix_inc_i,
    input  logic             win_adv_i,
    output logic [RD_AW-1:0] rd_addr_o,
    output logic [WR_AW-1:0] wr_addr_o,
    output logic             last_pix_o,
    output logic             last_win_o
);

    localparam int OW   = IMG_W - KERNEL_MxM + 1;
    localparam int OH   = IMG_H - KERNEL_MxM + 1;
    localparam int NPIX = KERNEL_MxM * KERNEL_MxM;
    localparam int CW   = $clog2(((IMG_W > IMG_H) ? IMG_W : IMG_H) + 1);
    localparam int KW   = $clog2(NPIX + 1);

    logic [CW-1:0] r_q, r_d, c_q, c_d;
    logic [KW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q <= '0;
            c_q <= '0;
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
        end
    end

    // k counts issued reads, so it reaches NPIX exactly while the final pixel is on the bus.
    always_comb begin
        r_d = r_q;
        c_d = c_q;
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        if (clr_i) begin
            r_d = '0;
            c_d = '0;
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end else if (win_adv_i) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
            if (c_q == CW'(OW - 1)) begin
                c_d = '0;
                r_d = r_q + CW'(1);
            end else begin
                c_d = c_q + CW'(1);
            end
        end else if (pix_inc_i) begin
            k_d = k_q + KW'(1);
            if (j_q == KW'(KERNEL_MxM - 1)) begin
                j_d = '0;
                i_d = i_q + KW'(1);
            end else begin
                j_d = j_q + KW'(1);
            end
        end
    end

    assign rd_addr_o  = (RD_AW'(r_q) + RD_AW'(i_q)) * RD_AW'(IMG_W) + RD_AW'(c_q) + RD_AW'(j_q);
    assign wr_addr_o  = WR_AW'(r_q) * WR_AW'(OW) + WR_AW'(c_q);
    assign last_pix_o = (k_q == KW'(NPIX));
    assign last_win_o = (r_q == CW'(OH - 1)) && (c_q == CW'(OW - 1));

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame scheduler driving the sobel window engine over every valid window of an image.
// Optional WAIT watchdog enabled by defining SOBEL_FRAME_CTRL_TIMEOUT_EN.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int KERNEL_MxM  = KERNEL_MXM_DEF,
    parameter int ARM_CYCLES  = 2,
    parameter int RD_AW       = 6,
    parameter int WR_AW       = 6,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk_i_s,
    input  logic             rst_i_s,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             rd_en_o,
    output logic [RD_AW-1:0] rd_addr_o,
    input  logic [PIX_W-1:0] rd_data_i,
    output logic             sob_en_o,
    output logic [PIX_W-1:0] sob_data_o,
    input  logic [PIX_W-1:0] sob_data_i,
    input  logic             sob_done_i,
    output logic             wr_en_o,
    output logic [WR_AW-1:0] wr_addr_o,
    output logic [PIX_W-1:0] wr_data_o
);

    localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

    if (IMG_W < KERNEL_MxM || IMG_H < KERNEL_MxM || ARM_CYCLES < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("sobel_frame_ctrl: unsupported parameter set");
    end

    sob_state_e       state_q, state_d;
    logic [ARM_W-1:0] arm_q, arm_d;
    logic [PIX_W-1:0] res_q, res_d;
    logic             err_q, err_d;

    logic             arm_last, to_expired;
    logic             clr, pix_inc, win_adv;
    logic [RD_AW-1:0] gen_rd_addr;
    logic [WR_AW-1:0] gen_wr_addr;
    logic             last_pix, last_win;

    sobel_win_addr_gen #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .KERNEL_MxM (KERNEL_MxM),
        .RD_AW      (RD_AW),
        .WR_AW      (WR_AW)
    ) u_addr (
        .clk_i      (clk_i_s),
        .rst_i      (rst_i_s),
        .clr_i      (clr),
        .pix_inc_i  (pix_inc),
        .win_adv_i  (win_adv),
        .rd_addr_o  (gen_rd_addr),
        .wr_addr_o  (gen_wr_addr),
        .last_pix_o (last_pix),
        .last_win_o (last_win)
    );

    assign arm_last = (arm_q == ARM_W'(ARM_CYCLES - 1));

`ifdef SOBEL_FRAME_CTRL_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] to_q, to_d;

    always_ff @(posedge clk_i_s or posedge rst_i_s) begin
        if (rst_i_s) to_q <= '0;
        else         to_q <= to_d;
    end

    assign to_d       = (state_q == ST_WAIT) ? to_q + TO_W'(1) : '0;
    assign to_expired = (state_q == ST_WAIT) && !sob_done_i && (to_q == TO_W'(TIMEOUT_CYC - 1));
`else
    assign to_expired = 1'b0;
`endif

    always_ff @(posedge clk_i_s or posedge rst_i_s) begin
        if (rst_i_s) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_ARM;
            ST_ARM:   if (arm_last) state_d = ST_FEED;
            ST_FEED:  if (last_pix) state_d = ST_WAIT;
            ST_WAIT:  if (sob_done_i || to_expired) state_d = ST_WRITE;
            ST_WRITE: state_d = ST_GAP;
            ST_GAP:   state_d = last_win ? ST_IDLE : ST_ARM;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i_s or posedge rst_i_s) begin
        if (rst_i_s) begin
            arm_q <= '0;
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            arm_q <= arm_d;
            res_q <= res_d;
            err_q <= err_d;
        end
    end

    // A done pulse before the window has been fully fed is flagged and otherwise ignored.
    always_comb begin
        arm_d = '0;
        res_d = res_q;
        err_d = err_q;
        unique case (state_q)
            ST_IDLE: if (start_i) err_d = 1'b0;
            ST_ARM: begin
                if (!arm_last) arm_d = arm_q + ARM_W'(1);
                if (sob_done_i) err_d = 1'b1;
            end
            ST_FEED: if (sob_done_i) err_d = 1'b1;
            ST_WAIT: begin
                if (sob_done_i) begin
                    res_d = sob_data_i;
                end else if (to_expired) begin
                    res_d = '0;
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_o     = (state_q != ST_IDLE);
        done_o     = 1'b0;
        err_o      = err_q;
        rd_en_o    = 1'b0;
        rd_addr_o  = '0;
        sob_en_o   = 1'b0;
        sob_data_o = '0;
        wr_en_o    = 1'b0;
        wr_addr_o  = '0;
        wr_data_o  = '0;
        clr        = 1'b0;
        win_adv    = 1'b0;
        unique case (state_q)
            ST_IDLE: clr = start_i;
            ST_ARM: begin
                sob_en_o = 1'b1;
                rd_en_o  = arm_last;
            end
            ST_FEED: begin
                sob_en_o   = 1'b1;
                sob_data_o = rd_data_i;
                rd_en_o    = !last_pix;
            end
            ST_WAIT: sob_en_o = 1'b1;
            ST_WRITE: begin
                wr_en_o   = 1'b1;
                wr_addr_o = gen_wr_addr;
                wr_data_o = res_q;
            end
            ST_GAP: begin
                done_o  = last_win;
                win_adv = !last_win;
            end
            default: ;
        endcase
        if (rd_en_o) rd_addr_o = gen_rd_addr;
        pix_inc = rd_en_o;
    end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl on a 4x4 image with a behavioural sobel and RAM model.
module tb_sobel_frame_ctrl;

    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int KM    = 3;
    localparam int ARM   = 2;
    localparam int RD_AW = 6;
    localparam int WR_AW = 6;
    localparam int TO    = 64;

    logic             clk_i_s = 1'b0;
    logic             rst_i_s = 1'b1;
    logic             start_i = 1'b0;
    logic             busy_o, done_o, err_o;
    logic             rd_en_o;
    logic [RD_AW-1:0] rd_addr_o;
    logic [7:0]       rd_data_i = '0;
    logic             sob_en_o;
    logic [7:0]       sob_data_o;
    logic [7:0]       sob_data_i = 8'hA5;
    logic             sob_done_i = 1'b0;
    logic             wr_en_o;
    logic [WR_AW-1:0] wr_addr_o;
    logic [7:0]       wr_data_o;

    sobel_frame_ctrl #(
        .IMG_W       (IMG_W),
        .IMG_H       (IMG_H),
        .KERNEL_MxM  (KM),
        .ARM_CYCLES  (ARM),
        .RD_AW       (RD_AW),
        .WR_AW       (WR_AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i_s    (clk_i_s),
        .rst_i_s    (rst_i_s),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .rd_en_o    (rd_en_o),
        .rd_addr_o  (rd_addr_o),
        .rd_data_i  (rd_data_i),
        .sob_en_o   (sob_en_o),
        .sob_data_o (sob_data_o),
        .sob_data_i (sob_data_i),
        .sob_done_i (sob_done_i),
        .wr_en_o    (wr_en_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o)
    );

    always #5 clk_i_s = ~clk_i_s;

    // Image RAM: RAM[a] = a, one cycle read latency.
    always @(posedge clk_i_s) if (rd_en_o) rd_data_i <= 8'(rd_addr_o);

    typedef struct packed {
        logic [0:8][7:0] pix;
        logic [7:0]      waddr;
        logic [7:0]      wdata;
        logic [7:0]      run;
    } vec_t;

    vec_t tbl [4];

    int n_checks = 0;
    int n_fail   = 0;

    int en_cnt = 0, low_run = 0, wr_cnt = 0, done_cnt = 0, cur = 0;
    bit seen = 1'b0, inject = 1'b0;
    int no_done_win = -1;
    logic [7:0]       pix_log [$];
    logic [RD_AW-1:0] rd_log  [$];
    logic [WR_AW-1:0] wa_log  [$];
    logic [7:0]       wd_log  [$];
    int               gap_log [$];
    int               run_log [$];

    // Sobel model: done three cycles after the ninth pixel, with optional early/missing pulses.
    always @(negedge clk_i_s) begin
        if (done_o) done_cnt++;
        if (rd_en_o) rd_log.push_back(rd_addr_o);
        if (wr_en_o) begin
            wa_log.push_back(wr_addr_o);
            wd_log.push_back(wr_data_o);
            wr_cnt++;
        end
        sob_done_i = 1'b0;
        if (sob_en_o) begin
            cur = en_cnt;
            en_cnt++;
            if (cur == 0) begin
                if (seen) gap_log.push_back(low_run);
                seen = 1'b1;
            end
            low_run = 0;
            if (cur >= ARM && cur < ARM + 9) pix_log.push_back(sob_data_o);
            if (cur == ARM + 11 && wr_cnt != no_done_win) sob_done_i = 1'b1;
            if (inject && wr_cnt == 1 && cur == ARM + 3) sob_done_i = 1'b1;
        end else begin
            if (en_cnt > 0) run_log.push_back(en_cnt);
            en_cnt = 0;
            low_run++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_logs();
        pix_log.delete(); rd_log.delete(); wa_log.delete(); wd_log.delete();
        gap_log.delete(); run_log.delete();
        wr_cnt = 0; done_cnt = 0; low_run = 0; seen = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk_i_s); #1 start_i = 1'b1;
        @(posedge clk_i_s); #1 start_i = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (done_o !== 1'b1 && n < bound) begin
            @(posedge clk_i_s); #1;
            n++;
        end
        chk("frame_done_seen", 32'(done_o), 32'd1);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},  32'(busy_o),     0);
        chk({tag, "_done"},  32'(done_o),     0);
        chk({tag, "_err"},   32'(err_o),      0);
        chk({tag, "_rd_en"}, 32'(rd_en_o),    0);
        chk({tag, "_raddr"}, 32'(rd_addr_o),  0);
        chk({tag, "_sen"},   32'(sob_en_o),   0);
        chk({tag, "_sdat"},  32'(sob_data_o), 0);
        chk({tag, "_wr_en"}, 32'(wr_en_o),    0);
        chk({tag, "_waddr"}, 32'(wr_addr_o),  0);
        chk({tag, "_wdata"}, 32'(wr_data_o),  0);
    endtask

    task automatic check_frame(input string tag, input logic exp_err);
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 9; k++) begin
                int idx = w * 9 + k;
                chk($sformatf("%s_pix_w%0d_k%0d", tag, w, k),
                    32'((idx < pix_log.size()) ? pix_log[idx] : 8'hEE), 32'(tbl[w].pix[k]));
                chk($sformatf("%s_rd_w%0d_k%0d", tag, w, k),
                    32'((idx < rd_log.size()) ? rd_log[idx] : 6'h3F), 32'(tbl[w].pix[k]));
            end
            chk($sformatf("%s_waddr_w%0d", tag, w),
                32'((w < wa_log.size()) ? wa_log[w] : 6'h3F), 32'(tbl[w].waddr));
            chk($sformatf("%s_wdata_w%0d", tag, w),
                32'((w < wd_log.size()) ? wd_log[w] : 8'hEE), 32'(tbl[w].wdata));
            chk($sformatf("%s_enrun_w%0d", tag, w),
                32'((w < run_log.size()) ? run_log[w] : -1), 32'(tbl[w].run));
        end
        chk({tag, "_nwrites"}, 32'(wa_log.size()), 4);
        chk({tag, "_ngaps"},   32'(gap_log.size()), 3);
        for (int g = 0; g < 3; g++)
            chk($sformatf("%s_gap%0d", tag, g), 32'((g < gap_log.size()) ? gap_log[g] : -1), 2);
        chk({tag, "_ndone"}, 32'(done_cnt), 1);
        chk({tag, "_err"},   32'(err_o), 32'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Per window: pixel addresses, write address, write data, cycles with sob_en_o high.
        tbl[0] = '{pix: {8'd0, 8'd1, 8'd2,  8'd4, 8'd5,  8'd6,  8'd8,  8'd9,  8'd10}, waddr: 8'd0, wdata: 8'hA5, run: 8'd14};
        tbl[1] = '{pix: {8'd1, 8'd2, 8'd3,  8'd5, 8'd6,  8'd7,  8'd9,  8'd10, 8'd11}, waddr: 8'd1, wdata: 8'hA5, run: 8'd14};
        tbl[2] = '{pix: {8'd4, 8'd5, 8'd6,  8'd8, 8'd9,  8'd10, 8'd12, 8'd13, 8'd14}, waddr: 8'd2, wdata: 8'hA5, run: 8'd14};
        tbl[3] = '{pix: {8'd5, 8'd6, 8'd7,  8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15}, waddr: 8'd3, wdata: 8'hA5, run: 8'd14};

        repeat (3) @(posedge clk_i_s);
        #1 chk_quiet("reset");
        rst_i_s = 1'b0;

        // Frame 1 with a stray start mid-frame, then start held across the done cycle.
        clear_logs();
        pulse_start();
        chk("busy_after_start", 32'(busy_o), 1);
        repeat (25) @(posedge clk_i_s);
        #1 start_i = 1'b1;
        @(posedge clk_i_s); #1 start_i = 1'b0;
        wait_done(400);
        start_i = 1'b1;
        @(posedge clk_i_s); #1;
        chk("start_in_done_cycle_ignored", 32'(busy_o), 0);
        check_frame("f1", 1'b0);
        clear_logs();
        @(posedge clk_i_s); #1 start_i = 1'b0;
        chk("start_after_done_accepted", 32'(busy_o), 1);
        wait_done(400);
        @(posedge clk_i_s); #1;
        check_frame("f2", 1'b0);
        chk("busy_low_after_frame", 32'(busy_o), 0);

        // Early done inside FEED of window 1.
        clear_logs();
        inject = 1'b1;
        pulse_start();
        wait_done(400);
        @(posedge clk_i_s); #1;
        check_frame("f3", 1'b1);
        inject = 1'b0;
        repeat (3) @(posedge clk_i_s);
        #1 chk("err_sticky", 32'(err_o), 1);
        clear_logs();
        pulse_start();
        chk("err_cleared_by_start", 32'(err_o), 0);
        wait_done(400);
        @(posedge clk_i_s); #1;
        check_frame("f4", 1'b0);

        // Reset during FEED of window 2.
        clear_logs();
        pulse_start();
        begin
            int n = 0;
            while (!(wr_cnt == 2 && en_cnt == ARM + 4) && n < 400) begin
                @(posedge clk_i_s); #1;
                n++;
            end
            chk("reached_w2_feed", 32'(sob_en_o && wr_cnt == 2), 1);
        end
        #2 rst_i_s = 1'b1;
        #1 chk_quiet("midreset");
        repeat (2) @(posedge clk_i_s);
        #1 rst_i_s = 1'b0;
        chk("midreset_nwrites", 32'(wa_log.size()), 2);
        chk("midreset_last_waddr", 32'((wa_log.size() > 0) ? wa_log[wa_log.size() - 1] : 6'h3F), 1);
        clear_logs();
        pulse_start();
        wait_done(400);
        @(posedge clk_i_s); #1;
        check_frame("f6", 1'b0);

`ifdef SOBEL_FRAME_CTRL_TIMEOUT_EN
        // Window 3 never answered: watchdog writes zero after 64 WAIT cycles.
        clear_logs();
        no_done_win = 3;
        pulse_start();
        wait_done(800);
        @(posedge clk_i_s); #1;
        chk("to_nwrites", 32'(wa_log.size()), 4);
        chk("to_waddr3", 32'((wa_log.size() > 3) ? wa_log[3] : 6'h3F), 3);
        chk("to_wdata3", 32'((wd_log.size() > 3) ? wd_log[3] : 8'hEE), 0);
        chk("to_wdata0", 32'((wd_log.size() > 0) ? wd_log[0] : 8'hEE), 32'h A5);
        chk("to_enrun3", 32'((run_log.size() > 3) ? run_log[3] : -1), ARM + 9 + TO);
        chk("to_err", 32'(err_o), 1);
        chk("to_ndone", 32'(done_cnt), 1);
        no_done_win = -1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
